// File: rtl/i2s_pkg.sv
// Shared constants for the I2S/TDM receiver: framing mode encodings
// and default word, slot and channel geometry.
package i2s_pkg;

  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  localparam int DEF_DATA_W   = 24;
  localparam int DEF_SLOT_W   = 32;
  localparam int DEF_CHANNELS = 2;

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchronizer for W async inputs; with EDGE=1 a third stage
// flags rising edges. Ports: i_d async in, o_lvl synced, o_rise edge.
module sync_edge #(
  parameter int W    = 1,
  parameter bit EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_lvl,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_lvl = r_s2;

  if (EDGE) begin : g_edge
    logic [W-1:0] r_s3;

    always_ff @(posedge clk) begin
      if (!rst) r_s3 <= '0;
      else      r_s3 <= r_s2;
    end

    assign o_rise = r_s2 & ~r_s3;
  end else begin : g_lvl
    assign o_rise = '0;
  end

endmodule

// File: rtl/i2s_rx_tdm.sv
// I2S / left-justified TDM receiver: deserializes CHANNELS slots per
// frame into DATA_W words and presents them on a valid/ready port.
// Ports: clk, rst (sync, active-low); bclk, lrclk, sdi async serial
// inputs; en ADC enable; adc_valid/adc_ready/adc_chan/adc_data word
// output; locked, frame_err (pulse), overrun (sticky) status.
module i2s_rx_tdm
  import i2s_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SLOT_W   = DEF_SLOT_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int MODE     = MODE_I2S
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lrclk,
  input  logic                        bclk,
  input  logic                        sdi,
  output logic                        en,
  output logic                        adc_valid,
  input  logic                        adc_ready,
  output logic [$clog2(CHANNELS)-1:0] adc_chan,
  output logic [DATA_W-1:0]           adc_data,
  output logic                        locked,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int TOT = CHANNELS * SLOT_W;
  localparam int CW  = $clog2(TOT);
  localparam int SW  = $clog2(SLOT_W);
  localparam int CHW = $clog2(CHANNELS);

  localparam logic [CW-1:0] LAST_POS = CW'(TOT - 1);

  logic              w_ev;
  logic              w_unused_blvl;
  logic [1:0]        w_lvl;
  logic [1:0]        w_unused_rise;
  logic              w_lr;
  logic              w_sd;
  logic              w_fs;
  logic [CW-1:0]     w_pos;
  logic [CW-1:0]     w_pos_nx;
  logic [SW-1:0]     w_bit;
  logic [CHW-1:0]    w_slot;
  logic              w_in_data;
  logic              w_last_dbit;
  logic              w_sync_ok;
  logic              w_err;
  logic              w_cap;
  logic              w_load;
  logic [DATA_W-1:0] w_word;

  logic              r_en;
  logic              r_valid;
  logic              r_locked;
  logic              r_ferr;
  logic              r_ovr;
  logic [DATA_W-1:0] r_data;
  logic [CHW-1:0]    r_chan;
  logic              r_lr_prev;
  logic [CW-1:0]     r_next;
  logic [DATA_W-2:0] r_sh;

  sync_edge #(
    .W    (1),
    .EDGE (1'b1)
  ) u_bclk (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bclk),
    .o_lvl  (w_unused_blvl),
    .o_rise (w_ev)
  );

  // lrclk and sdi share latency with the bclk level stage, so both
  // are valid together in the bit-event cycle.
  sync_edge #(
    .W    (2),
    .EDGE (1'b0)
  ) u_lvl (
    .clk    (clk),
    .rst    (rst),
    .i_d    ({lrclk, sdi}),
    .o_lvl  (w_lvl),
    .o_rise (w_unused_rise)
  );

  assign w_lr = w_lvl[1];
  assign w_sd = w_lvl[0];

  assign w_fs = w_ev & r_lr_prev & ~w_lr;

  // Position of the bit sampled now. A sync forces alignment: in I2S
  // the current bit is the frame's last, in LJ it is slot 0's MSB.
  always_comb begin
    w_pos = r_next;
    if (w_fs) w_pos = (MODE == MODE_LJ) ? '0 : LAST_POS;
  end

  assign w_pos_nx = (w_pos == LAST_POS) ? '0 : w_pos + CW'(1);

  assign w_bit  = w_pos[SW-1:0];
  assign w_slot = w_pos[CW-1:SW];

  assign w_in_data   = int'(w_bit) < DATA_W;
  assign w_last_dbit = int'(w_bit) == DATA_W - 1;

  // Where a well-formed stream would place this sync.
  assign w_sync_ok = (MODE == MODE_LJ) ? (r_next == '0)
                                       : (r_next == LAST_POS);

  assign w_err  = w_fs & r_locked & ~w_sync_ok;
  assign w_word = {r_sh, w_sd};
  assign w_cap  = w_ev & r_locked & w_last_dbit & ~w_err;
  assign w_load = w_cap & (~r_valid | adc_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en      <= 1'b0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_data    <= '0;
      r_chan    <= '0;
      r_lr_prev <= 1'b0;
      r_next    <= '0;
      r_sh      <= '0;
    end else begin
      r_en   <= 1'b1;
      r_ferr <= w_err;
      if (w_ev) begin
        r_lr_prev <= w_lr;
        r_next    <= w_pos_nx;
        // Restarting at bit 0 discards any partial word.
        if (w_in_data) begin
          if (w_bit == '0) r_sh <= {{(DATA_W-2){1'b0}}, w_sd};
          else             r_sh <= w_word[DATA_W-2:0];
        end
        if (w_fs) r_locked <= 1'b1;
      end
      if (w_load) begin
        r_data  <= w_word;
        r_chan  <= w_slot;
        r_valid <= 1'b1;
      end else if (r_valid && adc_ready) begin
        r_valid <= 1'b0;
      end
      if (w_cap && r_valid && !adc_ready) r_ovr <= 1'b1;
    end
  end

  assign en        = r_en;
  assign adc_valid = r_valid;
  assign adc_chan  = r_chan;
  assign adc_data  = r_data;
  assign locked    = r_locked;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_i2s_rx_tdm.sv
// Bench for i2s_rx_tdm: I2S 2x24 instance and LJ 4x16 TDM instance,
// serial streams built from slot tables, words checked on a queue.
module tb_i2s_rx_tdm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, bclk0, lr0, sd0, rdy0;
  logic        en0, v0, locked0, ferr0, ovr0;
  logic [0:0]  chan0;
  logic [23:0] data0;

  logic        rst1, bclk1, lr1, sd1, rdy1;
  logic        en1, v1, locked1, ferr1, ovr1;
  logic [1:0]  chan1;
  logic [15:0] data1;

  int n_checks = 0;
  int n_fail   = 0;
  int nferr0   = 0;
  int nferr1   = 0;

  logic [24:0] q0[$];
  logic [17:0] q1[$];
  logic [31:0] sl [8];

  i2s_rx_tdm u_dut0 (
    .clk       (clk),
    .rst       (rst0),
    .lrclk     (lr0),
    .bclk      (bclk0),
    .sdi       (sd0),
    .en        (en0),
    .adc_valid (v0),
    .adc_ready (rdy0),
    .adc_chan  (chan0),
    .adc_data  (data0),
    .locked    (locked0),
    .frame_err (ferr0),
    .overrun   (ovr0)
  );

  i2s_rx_tdm #(
    .DATA_W   (16),
    .SLOT_W   (32),
    .CHANNELS (4),
    .MODE     (1)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst1),
    .lrclk     (lr1),
    .bclk      (bclk1),
    .sdi       (sd1),
    .en        (en1),
    .adc_valid (v1),
    .adc_ready (rdy1),
    .adc_chan  (chan1),
    .adc_data  (data1),
    .locked    (locked1),
    .frame_err (ferr1),
    .overrun   (ovr1)
  );

  // One bclk period (40 ns): data and lrclk change while bclk is low.
  task automatic bit_tx(input int sel, input logic lr, input logic d);
    if (sel == 0) begin
      bclk0 = 1'b0; lr0 = lr; sd0 = d;
    end else begin
      bclk1 = 1'b0; lr1 = lr; sd1 = d;
    end
    #20;
    if (sel == 0) bclk0 = 1'b1;
    else          bclk1 = 1'b1;
    #20;
  endtask

  // Sends frame bits 0..stop-1; lrclk is low in the first half of the
  // frame, shifted one bit early for I2S. Pushes expected words.
  task automatic frame_tx(input int sel, input logic [31:0] s [8],
                          input bit exp_w, input int stop,
                          input bit hold);
    int nch, dw, tot, q, si, bi;
    logic lr;
    nch = (sel == 0) ? 2 : 4;
    dw  = (sel == 0) ? 24 : 16;
    tot = nch * 32;
    for (int k = 0; k < tot; k++) begin
      if (k >= stop) return;
      si = k / 32;
      bi = k % 32;
      q  = (sel == 0) ? (k + 1) % tot : k;
      lr = hold ? 1'b1 : (q >= tot / 2);
      if (exp_w && bi == dw - 1) begin
        if (sel == 0) q0.push_back({1'(si), s[si][31 -: 24]});
        else          q1.push_back({2'(si), s[si][31 -: 16]});
      end
      bit_tx(sel, lr, s[si][31 - bi]);
    end
  endtask

  task automatic monitor();
    logic [24:0] e0;
    logic [17:0] e1;
    forever begin
      @(negedge clk);
      if (ferr0) nferr0++;
      if (ferr1) nferr1++;
      if (v0 && rdy0) begin
        n_checks++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL sb0_unexpected: got chan=%0d data=%h, required no word",
                   chan0, data0);
        end else begin
          e0 = q0.pop_front();
          if ({chan0, data0} !== e0) begin
            n_fail++;
            $display("FAIL sb0_word: got chan=%0d data=%h, required chan=%0d data=%h",
                     chan0, data0, e0[24], e0[23:0]);
          end
        end
      end
      if (v1 && rdy1) begin
        n_checks++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL sb1_unexpected: got chan=%0d data=%h, required no word",
                   chan1, data1);
        end else begin
          e1 = q1.pop_front();
          if ({chan1, data1} !== e1) begin
            n_fail++;
            $display("FAIL sb1_word: got chan=%0d data=%h, required chan=%0d data=%h",
                     chan1, data1, e1[17:16], e1[15:0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b0; rst1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
    bclk0 = 1'b1; bclk1 = 1'b1;
    lr0 = 1'b0; lr1 = 1'b0; sd0 = 1'b0; sd1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({en0, v0, locked0, ferr0, ovr0, chan0, data0} !== '0) begin
      n_fail++;
      $display("FAIL reset0: got en=%b v=%b lk=%b fe=%b ov=%b ch=%0d d=%h, required all 0",
               en0, v0, locked0, ferr0, ovr0, chan0, data0);
    end
    n_checks++;
    if ({en1, v1, locked1, ferr1, ovr1, chan1, data1} !== '0) begin
      n_fail++;
      $display("FAIL reset1: got en=%b v=%b lk=%b fe=%b ov=%b ch=%0d d=%h, required all 0",
               en1, v1, locked1, ferr1, ovr1, chan1, data1);
    end
    @(posedge clk);
    #1;
    rst0 = 1'b1; rst1 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (en0 !== 1'b0) begin
      n_fail++;
      $display("FAIL en_release0: got %b, required 0", en0);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({en0, en1} !== 2'b11) begin
      n_fail++;
      $display("FAIL en_rise: got %b%b, required 11", en0, en1);
    end
  endtask

  task automatic test_prelock();
    for (int i = 0; i < 60; i++) bit_tx(0, i >= 20, 1'($urandom));
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({locked0, v0} !== 2'b00) begin
      n_fail++;
      $display("FAIL prelock: got locked=%b valid=%b, required 0 0",
               locked0, v0);
    end
  endtask

  task automatic test_i2s();
    for (int i = 0; i < 4; i++) bit_tx(0, 1'b1, 1'($urandom));
    bit_tx(0, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      sl[0] = (f < 2) ? 32'h12345678 : $urandom;
      sl[1] = (f < 2) ? 32'h12345678 : $urandom;
      frame_tx(0, sl, 1'b1, 64, 1'b0);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL i2s_missing: got %0d words pending, required 0",
               q0.size());
    end
    n_checks++;
    if (locked0 !== 1'b1 || nferr0 != 0) begin
      n_fail++;
      $display("FAIL i2s_status: got locked=%b ferr_pulses=%0d, required 1 0",
               locked0, nferr0);
    end
  endtask

  task automatic test_frame_err();
    int e;
    e = nferr0;
    sl[0] = 32'hCAFEBABE;
    sl[1] = 32'h0BADF00D;
    frame_tx(0, sl, 1'b1, 42, 1'b0);
    bit_tx(0, 1'b0, 1'b1);
    sl[0] = 32'h13579BDF;
    sl[1] = 32'h2468ACE0;
    frame_tx(0, sl, 1'b1, 64, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (nferr0 != e + 1) begin
      n_fail++;
      $display("FAIL frame_err_count: got %0d pulses, required %0d",
               nferr0 - e, 1);
    end
    n_checks++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL frame_err_words: got %0d pending, required 0",
               q0.size());
    end
  endtask

  task automatic test_overrun();
    @(posedge clk);
    #1;
    rdy0 = 1'b0;
    sl[0] = 32'hA1B2C3D4;
    sl[1] = 32'h55AA33CC;
    q0.push_back({1'b0, 24'hA1B2C3});
    frame_tx(0, sl, 1'b0, 64, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({v0, chan0, data0} !== {1'b1, 1'b0, 24'hA1B2C3}) begin
      n_fail++;
      $display("FAIL ovr_hold: got v=%b ch=%0d d=%h, required v=1 ch=0 d=a1b2c3",
               v0, chan0, data0);
    end
    n_checks++;
    if (ovr0 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_flag: got %b, required 1", ovr0);
    end
    @(posedge clk);
    #1;
    rdy0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (v0 !== 1'b0 || q0.size() != 0) begin
      n_fail++;
      $display("FAIL ovr_drain: got v=%b pending=%0d, required 0 0",
               v0, q0.size());
    end
  endtask

  task automatic test_reset_mid();
    sl[0] = $urandom;
    sl[1] = $urandom;
    frame_tx(0, sl, 1'b0, 10, 1'b0);
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({en0, v0, locked0, ferr0, ovr0, chan0, data0} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got en=%b v=%b lk=%b fe=%b ov=%b ch=%0d d=%h, required all 0",
               en0, v0, locked0, ferr0, ovr0, chan0, data0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({en0, locked0} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_mid_release: got en=%b locked=%b, required 1 0",
               en0, locked0);
    end
    for (int i = 0; i < 5; i++) bit_tx(0, 1'b1, 1'($urandom));
    n_checks++;
    if (locked0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_nolock: got %b, required 0", locked0);
    end
    bit_tx(0, 1'b0, 1'b0);
    sl[0] = 32'hFEDCBA98;
    sl[1] = 32'h00FF00FF;
    frame_tx(0, sl, 1'b1, 64, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q0.size() != 0 || locked0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_resume: got pending=%0d locked=%b, required 0 1",
               q0.size(), locked0);
    end
  endtask

  task automatic test_tdm_lj();
    for (int i = 0; i < 3; i++) bit_tx(1, 1'b1, 1'($urandom));
    sl[0] = 32'hA5A51234;
    sl[1] = 32'h1111ABCD;
    sl[2] = 32'h22220F0F;
    sl[3] = 32'h33335555;
    frame_tx(1, sl, 1'b1, 128, 1'b0);
    for (int c = 0; c < 4; c++) sl[c] = $urandom;
    frame_tx(1, sl, 1'b1, 128, 1'b0);
    for (int c = 0; c < 4; c++) sl[c] = $urandom;
    frame_tx(1, sl, 1'b1, 128, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL tdm_missing: got %0d pending, required 0", q1.size());
    end
    n_checks++;
    if (locked1 !== 1'b1 || nferr1 != 0 || ovr1 !== 1'b0) begin
      n_fail++;
      $display("FAIL tdm_status: got lk=%b fe=%0d ov=%b, required 1 0 0",
               locked1, nferr1, ovr1);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_prelock();
    test_i2s();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_tdm_lj();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_rx_tdm.md
I2S_RX_TDM -- requirements
Module: i2s_rx_tdm

Interface
REQ-001 Parameter DATA_W, default 24, is the received word width (8..32).
REQ-002 Parameter SLOT_W, default 32, is the bits per channel slot (power of 2, at least DATA_W).
REQ-003 Parameter CHANNELS, default 2, is the slots per frame (2..8).
REQ-004 Parameter MODE, default 0, selects framing: 0 = I2S (one-bit delay after frame sync), 1 = left-justified (no delay).
REQ-005 clk  in  1  system clock; frequency at least 4x bclk.
REQ-006 rst  in  1  reset; one clock, reset is synchronous and active-low.
REQ-007 lrclk  in  1  frame sync from ADC, asynchronous to clk.
REQ-008 bclk  in  1  bit clock from ADC, asynchronous to clk.
REQ-009 sdi  in  1  serial data, MSB first, changes on bclk falling edge.
REQ-010 en  out  1  ADC enable.
REQ-011 adc_valid  out  1  word available.
REQ-012 adc_ready  in  1  consumer accepts the word when high with adc_valid.
REQ-013 adc_chan  out  clog2(CHANNELS)  slot index of the word.
REQ-014 adc_data  out  DATA_W  received word.
REQ-015 locked  out  1  a frame sync has been seen.
REQ-016 frame_err  out  1  one-clk pulse on a frame-length mismatch.
REQ-017 overrun  out  1  sticky: a word was dropped.

Function
REQ-018 bclk, lrclk and sdi SHALL each pass through a 2-FF synchronizer; a third bclk stage SHALL detect rising edges ("bit event").
REQ-019 At each bit event, the block SHALL sample the synchronized lrclk and sdi together.
REQ-020 A frame sync SHALL occur when lrclk is 1 at the previous bit event and 0 at the current one.
REQ-021 At a frame sync, MODE 0: the sdi of the next bit event SHALL be bit 0 (MSB) of slot 0.
REQ-022 At a frame sync, MODE 1: the sdi of the current bit event SHALL be bit 0 (MSB) of slot 0.
REQ-023 The frame bit counter SHALL span 0..CHANNELS*SLOT_W-1; slot = counter / SLOT_W, bit = counter mod SLOT_W.
REQ-024 If the counter reaches its end without a frame sync, it SHALL wrap to 0 and continue.
REQ-025 Slot bits 0..DATA_W-1 SHALL shift into the word MSB first; bits DATA_W..SLOT_W-1 SHALL be ignored.
REQ-026 When bit DATA_W-1 of a slot is captured, the word SHALL be complete; output presentation follows the handshake below.
REQ-027 Output presentation: if adc_valid is low, or high with adc_ready high, adc_data/adc_chan SHALL load and adc_valid SHALL be 1 on the next clk.
REQ-028 Latency: adc_valid SHALL rise 1 clk after the bit-event cycle of the final data bit.
REQ-029 adc_valid/adc_data/adc_chan SHALL hold stable until adc_ready is high with adc_valid; adc_valid then falls unless a new word loads in the same cycle.
REQ-030 Word complete while adc_valid=1 and adc_ready=0: the new word SHALL be dropped and overrun set to 1 until reset.
REQ-031 Before locked=1, no words SHALL be emitted; locked SHALL set at the first frame sync and hold until reset.
REQ-032 A frame sync while locked with counter position != last SHALL pulse frame_err for 1 clk, drop any partial word, and resynchronize per REQ-021/REQ-022.
REQ-033 In MODE 0, a frame sync coinciding with the last frame bit is the normal case and SHALL NOT raise frame_err.
REQ-034 en SHALL go to 1 on the first clk after rst deasserts and stay 1.

Reset
REQ-035 While rst=0, on every clk edge: en, adc_valid, locked, frame_err, overrun = 0; adc_data, adc_chan = 0; counter, shift register and synchronizers cleared.
REQ-036 Reset asserted mid-word SHALL discard the partial word; after release, output resumes only after a new frame sync.

Structure
REQ-037 The MODE encodings and the defaults for DATA_W, SLOT_W and CHANNELS SHALL live in the shared package i2s_pkg.
REQ-038 The synchronizer plus edge detector SHALL be one sub-module, sync_edge, instantiated for bclk (with edge output) and for lrclk/sdi (level only).

Verification
REQ-039 Default parameters, MODE 0, bclk=25 MHz, clk=100 MHz, each slot carrying 0x12345678 -> alternating words adc_chan 0/1 with adc_data 0x123456, no frame_err.
REQ-040 CHANNELS=4, DATA_W=16, MODE 1, slots 0xA5A5xxxx/0x1111/0x2222/0x3333 -> adc_chan 0,1,2,3 with data 0xA5A5, 0x1111, 0x2222, 0x3333.
REQ-041 adc_ready held 0 across two words -> first word held stable, second dropped, overrun=1; after adc_ready=1, adc_valid falls.
REQ-042 lrclk falling edge injected at bit 10 of slot 1 -> one frame_err pulse, partial word not emitted, next frame decoded correctly.
REQ-043 Stimulus starts mid-frame before the first frame sync -> no adc_valid until locked=1.
REQ-044 rst=0 asserted mid-word for 3 clk -> all outputs 0 next clk; after release, en=1 one clk later and locked=0 until the next frame sync.
